// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with a sequencing FSM. Optional macro: DIV_ZERO_TRAP_EN adds div_zero_o.
// Latency: start accepted at E0, ready_o registered at E33 (E1 for a zero divisor).
// Backpressure: result and ready_o are held while start_i stays high; annul_i aborts, start_i outside FREE is ignored.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic               div_zero_o
`endif
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH:0]   partial_q;   // {remainder window, dividend/quotient bits, shift slot}
  logic [WIDTH-1:0]   divisor_q;
  logic               sign1_q;
  logic               sign2_q;
  logic               signed_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
`ifdef DIV_ZERO_TRAP_EN
  logic               div_zero_q;
`endif

  logic [WIDTH-1:0]   op1_mag_d;
  logic [WIDTH-1:0]   op2_mag_d;
  logic [WIDTH:0]     diff_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_d;

  // Operand magnitudes, trial subtraction and final sign fix-up
  always_comb begin
    op1_mag_d = opdata1_i;
    op2_mag_d = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      op1_mag_d = ~opdata1_i + 1'b1;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      op2_mag_d = ~opdata2_i + 1'b1;
    end

    // 33-bit subtract: bit WIDTH set means the divisor did not fit
    diff_d = {1'b0, partial_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};

    quot_d = partial_q[WIDTH-1:0];
    rem_d  = partial_q[2*WIDTH:WIDTH+1];
    if (signed_q && (sign1_q ^ sign2_q)) begin
      quot_d = ~partial_q[WIDTH-1:0] + 1'b1;
    end
    // Remainder takes the sign of the dividend
    if (signed_q && sign1_q) begin
      rem_d = ~partial_q[2*WIDTH:WIDTH+1] + 1'b1;
    end
  end

  // Sequencing FSM with registered result, ready and trap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      partial_q  <= '0;
      divisor_q  <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        FREE: begin
          // annul_i beats a simultaneous start_i
          if (start_i && !annul_i) begin
            sign1_q  <= opdata1_i[WIDTH-1];
            sign2_q  <= opdata2_i[WIDTH-1];
            signed_q <= signed_div_i;
            if (opdata2_i == '0) begin
              state_q <= BYZERO;
            end else begin
              state_q   <= ON;
              cnt_q     <= '0;
              partial_q <= {{WIDTH{1'b0}}, op1_mag_d, 1'b0};
              divisor_q <= op2_mag_d;
            end
          end
        end

        BYZERO: begin
          if (annul_i) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
          end else begin
            state_q    <= END;
            result_q   <= '0;
            ready_q    <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_q <= 1'b1;
`endif
          end
        end

        ON: begin
          if (annul_i) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            state_q  <= END;
            result_q <= {rem_d, quot_d};
            ready_q  <= 1'b1;
          end else begin
            if (diff_d[WIDTH]) begin
              partial_q <= {partial_q[2*WIDTH-1:0], 1'b0};
            end else begin
              partial_q <= {diff_d[WIDTH-1:0], partial_q[WIDTH-1:0], 1'b1};
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        END: begin
          // Result is held until EX drops start_i or the op is killed
          if (annul_i || !start_i) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            result_q   <= '0;
            ready_q    <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_q <= 1'b0;
`endif
          end
        end

        default: begin
          state_q <= FREE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: unsigned/signed divides, zero divisor,
// annul in several states, asynchronous reset mid-operation and in END.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_o;
`endif

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .div_zero_o   (div_zero_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request and pass edge E0; then scramble operands to show they are ignored
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    signed_div_i = ~sgn;
    opdata1_i    = 32'hDEAD_BEEF;
    opdata2_i    = 32'h0000_0003;
  endtask

  // Count edges after E0 until ready_o, bounded
  task automatic wait_ready(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (!ready_o && n < 60) begin
      tick();
      n++;
    end
    checkint({tag, "_latency"}, n, exp_edges);
  endtask

  // Drop start_i and confirm the outputs clear one edge later
  task automatic release_op(input string tag);
    start_i = 1'b0;
    tick();
    check1({tag, "_ready_clr"}, ready_o, 1'b0);
    check64({tag, "_result_clr"}, result_o, 64'h0);
  endtask

  // ready_o must never rise over n edges
  task automatic quiet(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ready_o) hits++;
    end
    checkint(tag, hits, 0);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check1("reset_ready", ready_o, 1'b0);
    check64("reset_result", result_o, 64'h0);
`ifdef DIV_ZERO_TRAP_EN
    check1("reset_div_zero", div_zero_o, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // DIVU 100/7 -> q=14, r=2; hold one extra cycle with start high
    launch(1'b0, 32'd100, 32'd7);
    wait_ready("divu_100_7", 33);
    check64("divu_100_7_result", result_o, 64'h00000002_0000000E);
    tick();
    check1("divu_hold_ready", ready_o, 1'b1);
    check64("divu_hold_result", result_o, 64'h00000002_0000000E);
    release_op("divu_100_7");

    // DIV -7/2 -> q=-3, r=-1
    launch(1'b1, 32'hFFFF_FFF9, 32'h2);
    wait_ready("div_m7_2", 33);
    check64("div_m7_2_result", result_o, 64'hFFFFFFFF_FFFFFFFD);
    release_op("div_m7_2");

    // DIV 7/-2 -> q=-3, r=1
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready("div_7_m2", 33);
    check64("div_7_m2_result", result_o, 64'h00000001_FFFFFFFD);
    release_op("div_7_m2");

    // DIVU 0xFFFFFFF9/2: same bits as -7 but unsigned -> q=0x7FFFFFFC, r=1
    launch(1'b0, 32'hFFFF_FFF9, 32'h2);
    wait_ready("divu_fff9_2", 33);
    check64("divu_fff9_2_result", result_o, 64'h00000001_7FFFFFFC);
    release_op("divu_fff9_2");

    // DIVU 5/0 -> ready after E1, result 0
    launch(1'b0, 32'd5, 32'd0);
    wait_ready("divu_zero", 1);
    check64("divu_zero_result", result_o, 64'h0);
`ifdef DIV_ZERO_TRAP_EN
    check1("divu_zero_flag", div_zero_o, 1'b1);
`endif
    release_op("divu_zero");
`ifdef DIV_ZERO_TRAP_EN
    check1("divu_zero_flag_clr", div_zero_o, 1'b0);
`endif

    // Annul at iteration 10, then a fresh DIVU 0xFFFFFFFF/0x10
    launch(1'b0, 32'd1000, 32'd3);
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check1("annul_on_ready", ready_o, 1'b0);
    quiet("annul_on_quiet", 40);
    launch(1'b0, 32'hFFFF_FFFF, 32'h10);
    wait_ready("divu_ffff_10", 33);
    check64("divu_ffff_10_result", result_o, 64'h0000000F_0FFFFFFF);
    release_op("divu_ffff_10");

    // start and annul together in FREE: no launch
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    quiet("start_annul_free_quiet", 40);

    // DIV -100/-7 -> q=14, r=-2; then annul while held in END
    launch(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_ready("div_m100_m7", 33);
    check64("div_m100_m7_result", result_o, 64'hFFFFFFFE_0000000E);
    annul_i = 1'b1;
    tick();
    check1("annul_end_ready", ready_o, 1'b0);
    check64("annul_end_result", result_o, 64'h0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Signed corner 0x80000000 / -1 wraps to 0x80000000, remainder 0
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready("div_corner", 33);
    check64("div_corner_result", result_o, 64'h00000000_80000000);
    release_op("div_corner");

    // Reset at iteration 20, then a normal op after release
    launch(1'b0, 32'd12345, 32'd67);
    repeat (20) tick();
    #2 rst = 1'b1;
    start_i = 1'b0;
    #1;
    check1("rst_on_ready", ready_o, 1'b0);
    check64("rst_on_result", result_o, 64'h0);
    #2 rst = 1'b0;
    quiet("rst_on_quiet", 40);

    // DIVU 3/10 -> q=0, r=3, then asynchronous reset while ready is high
    launch(1'b0, 32'd3, 32'd10);
    wait_ready("divu_3_10", 33);
    check64("divu_3_10_result", result_o, 64'h00000003_00000000);
    #2 rst = 1'b1;
    start_i = 1'b0;
    #1;
    check1("rst_end_ready", ready_o, 1'b0);
    check64("rst_end_result", result_o, 64'h0);
    #2 rst = 1'b0;
    tick();

    // Post-reset op completes at E33: 12345/67 -> q=184, r=17
    launch(1'b0, 32'd12345, 32'd67);
    wait_ready("divu_after_rst", 33);
    check64("divu_after_rst_result", result_o, 64'h00000011_000000B8);
    release_op("divu_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
